// File: rtl/cacheline_burst_adapter.sv
// Cache-line to pmem burst adapter: moves one whole cache line as a
// BURST_LEN-beat read or write burst on the physical-memory interface.
module cacheline_burst_adapter #(
  parameter int BURST_LEN        = 4,
  parameter int CACHE_LINE_WIDTH = 256,
  localparam int BURST_WIDTH     = CACHE_LINE_WIDTH / BURST_LEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        line_read,
  input  logic                        line_write,
  input  logic [31:0]                 line_addr,
  input  logic [CACHE_LINE_WIDTH-1:0] line_wdata,
  output logic [CACHE_LINE_WIDTH-1:0] line_rdata,
  output logic                        line_resp,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [31:0]                 pmem_addr,
  output logic [BURST_WIDTH-1:0]      pmem_wdata,
  input  logic                        pmem_resp,
  input  logic [BURST_WIDTH-1:0]      pmem_rdata
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  // Byte-offset bits inside a line are dropped so pmem only sees aligned lines.
  localparam logic [31:0] ADDR_MASK = ~32'(CACHE_LINE_WIDTH / 8 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BURST_WIDTH-1:0] wbuf_q  [BURST_LEN];
  logic [BURST_WIDTH-1:0] rbeat_q [BURST_LEN];
  logic                   pmem_read_q;
  logic                   pmem_write_q;
  logic [31:0]            pmem_addr_q;
  logic                   line_resp_q;
  logic [31:0]            addr_aligned_d;

  assign addr_aligned_d = line_addr & ADDR_MASK;

  assign pmem_read  = pmem_read_q;
  assign pmem_write = pmem_write_q;
  assign pmem_addr  = pmem_addr_q;
  assign line_resp  = line_resp_q;

  // Current write beat is selected straight from the counter so beat 0 is
  // already on the bus in the first WRITE cycle.
  assign pmem_wdata = wbuf_q[cnt_q];

  // Captured read beats are presented as one flat line.
  for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_rdata
    assign line_rdata[gi*BURST_WIDTH +: BURST_WIDTH] = rbeat_q[gi];
  end

  // Burst FSM: accepts a line request, counts beats on pmem_resp, pulses done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
      line_resp_q  <= 1'b0;
      for (int i = 0; i < BURST_LEN; i++) begin
        wbuf_q[i]  <= '0;
        rbeat_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          line_resp_q <= 1'b0;
          if (line_write) begin
            for (int i = 0; i < BURST_LEN; i++) begin
              wbuf_q[i] <= line_wdata[i*BURST_WIDTH +: BURST_WIDTH];
            end
            pmem_addr_q  <= addr_aligned_d;
            cnt_q        <= '0;
            pmem_write_q <= 1'b1;
            state_q      <= S_WRITE;
          end else if (line_read) begin
            pmem_addr_q <= addr_aligned_d;
            cnt_q       <= '0;
            pmem_read_q <= 1'b1;
            state_q     <= S_READ;
          end
        end
        S_READ: begin
          if (pmem_resp) begin
            rbeat_q[cnt_q] <= pmem_rdata;
            if (cnt_q == LAST_BEAT) begin
              // Drop the request on this very edge so memory never sees a
              // second read start.
              pmem_read_q <= 1'b0;
              line_resp_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (pmem_resp) begin
            if (cnt_q == LAST_BEAT) begin
              pmem_write_q <= 1'b0;
              line_resp_q  <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          line_resp_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Self-checking bench for cacheline_burst_adapter: a beat-addressed memory
// model answers bursts with chosen delays; line results are checked against it.
module tb_cacheline_burst_adapter;

  localparam int LEN = 4;
  localparam int LW  = 256;
  localparam int BW  = LW / LEN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_read = 1'b0;
  logic          line_write = 1'b0;
  logic [31:0]   line_addr = '0;
  logic [LW-1:0] line_wdata = '0;
  logic [LW-1:0] line_rdata;
  logic          line_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_addr;
  logic [BW-1:0] pmem_wdata;
  logic          pmem_resp = 1'b0;
  logic [BW-1:0] pmem_rdata = '0;

  int checks = 0;
  int errors = 0;
  logic [LW-1:0] last_rdata = '0;
  logic [BW-1:0] mem [logic [31:0]];

  cacheline_burst_adapter #(.BURST_LEN(LEN), .CACHE_LINE_WIDTH(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_read  (line_read),
    .line_write (line_write),
    .line_addr  (line_addr),
    .line_wdata (line_wdata),
    .line_rdata (line_rdata),
    .line_resp  (line_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_resp  (pmem_resp),
    .pmem_rdata (pmem_rdata)
  );

  always #5 clk = ~clk;

  // Memory content for a beat address; untouched locations get random data.
  function automatic logic [BW-1:0] mem_beat(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  // One full transaction; starts and ends at a negedge with the DUT idle.
  task automatic run_txn(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                         input logic [LW-1:0] wline, input int d0, input int gap,
                         input string tag);
    logic [31:0]   base;
    logic [LW-1:0] exp_line;
    bit            is_wr;
    int            w;
    base  = addr & 32'hFFFF_FFE0;
    is_wr = do_wr;
    $display("txn %s: %s addr=%h base=%h d0=%0d gap=%0d", tag, is_wr ? "write" : "read",
             addr, base, d0, gap);
    line_read = do_rd; line_write = do_wr; line_addr = addr; line_wdata = wline;
    @(posedge clk); @(negedge clk);
    // Request inputs are free to change after acceptance.
    line_read = 1'b0; line_write = 1'b0;
    line_addr = $urandom; line_wdata = {8{$urandom}};
    for (int b = 0; b < LEN; b++) begin
      w = (b == 0) ? d0 : gap;
      for (int c = 0; c <= w; c++) begin
        checks++;
        if (pmem_read !== !is_wr) begin
          errors++; $display("FAIL %s pmem_read beat%0d: got %b want %b", tag, b, pmem_read, !is_wr);
        end
        checks++;
        if (pmem_write !== is_wr) begin
          errors++; $display("FAIL %s pmem_write beat%0d: got %b want %b", tag, b, pmem_write, is_wr);
        end
        checks++;
        if (pmem_addr !== base) begin
          errors++; $display("FAIL %s pmem_addr beat%0d: got %h want %h", tag, b, pmem_addr, base);
        end
        checks++;
        if (line_resp !== 1'b0) begin
          errors++; $display("FAIL %s early line_resp beat%0d: got %b want 0", tag, b, line_resp);
        end
        if (is_wr) begin
          checks++;
          if (pmem_wdata !== wline[BW*b +: BW]) begin
            errors++; $display("FAIL %s pmem_wdata beat%0d: got %h want %h", tag, b, pmem_wdata, wline[BW*b +: BW]);
          end
        end
        if (c == w) begin
          pmem_resp = 1'b1;
          if (is_wr) begin
            mem[base + 32'(8*b)] = pmem_wdata;
            pmem_rdata = {$urandom, $urandom};
          end else begin
            pmem_rdata = mem_beat(base + 32'(8*b));
          end
        end else begin
          pmem_resp  = 1'b0;
          pmem_rdata = {$urandom, $urandom};
        end
        @(posedge clk); @(negedge clk);
      end
    end
    pmem_resp = 1'b0;
    for (int i = 0; i < LEN; i++) exp_line[BW*i +: BW] = mem_beat(base + 32'(8*i));
    // DONE cycle: requests gone, single response pulse.
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errors++; $display("FAIL %s req after last beat: got rd=%b wr=%b want 0 0", tag, pmem_read, pmem_write);
    end
    checks++;
    if (line_resp !== 1'b1) begin
      errors++; $display("FAIL %s line_resp done: got %b want 1", tag, line_resp);
    end
    if (!is_wr) last_rdata = exp_line;
    checks++;
    if (line_rdata !== last_rdata) begin
      errors++; $display("FAIL %s line_rdata: got %h want %h", tag, line_rdata, last_rdata);
    end
    // A stray beat strobe outside a burst must be ignored.
    pmem_resp = 1'($urandom);
    @(posedge clk); @(negedge clk);
    pmem_resp = 1'b0;
    checks++;
    if (line_resp !== 1'b0) begin
      errors++; $display("FAIL %s line_resp width: got %b want 0", tag, line_resp);
    end
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errors++; $display("FAIL %s idle req: got rd=%b wr=%b want 0 0", tag, pmem_read, pmem_write);
    end
    checks++;
    if (line_rdata !== last_rdata) begin
      errors++; $display("FAIL %s line_rdata hold: got %h want %h", tag, line_rdata, last_rdata);
    end
    if (is_wr) begin
      checks++;
      if (exp_line !== wline) begin
        errors++; $display("FAIL %s memory image: got %h want %h", tag, exp_line, wline);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || line_resp !== 1'b0) begin
      errors++; $display("FAIL reset ctl: got rd=%b wr=%b resp=%b want 0 0 0", pmem_read, pmem_write, line_resp);
    end
    checks++;
    if (pmem_addr !== 32'h0 || pmem_wdata !== '0) begin
      errors++; $display("FAIL reset pmem: got addr=%h wdata=%h want 0 0", pmem_addr, pmem_wdata);
    end
    checks++;
    if (line_rdata !== '0) begin
      errors++; $display("FAIL reset line_rdata: got %h want 0", line_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errors++; $display("FAIL post-reset idle: got rd=%b wr=%b want 0 0", pmem_read, pmem_write);
    end
    $display("txn reset: done");
  endtask

  task automatic test_read();
    mem[32'h1220] = 64'h1111_1111_1111_1111;
    mem[32'h1228] = 64'h2222_2222_2222_2222;
    mem[32'h1230] = 64'h3333_3333_3333_3333;
    mem[32'h1238] = 64'h4444_4444_4444_4444;
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 2, 0, "read");
    checks++;
    if (line_rdata !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
      errors++; $display("FAIL read line: got %h want 4444..3333..2222..1111", line_rdata);
    end
  endtask

  task automatic test_write();
    logic [LW-1:0] wl;
    wl = {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
          64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
    run_txn(1'b0, 1'b1, 32'h0000_0040, wl, 1, 0, "write");
    run_txn(1'b1, 1'b0, 32'h0000_0040, '0, 0, 0, "readback");
    checks++;
    if (line_rdata !== wl) begin
      errors++; $display("FAIL readback 0x40: got %h want %h", line_rdata, wl);
    end
  endtask

  task automatic test_both();
    run_txn(1'b1, 1'b1, 32'h0000_0160, {8{$urandom}}, 0, 1, "both");
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 1'b0, 32'h0000_0080, '0, 0, 0, "b2b_a");
    run_txn(1'b1, 1'b0, 32'h0000_00A0, '0, 1, 0, "b2b_b");
  endtask

  task automatic test_stall();
    run_txn(1'b0, 1'b1, 32'h0000_0200, {8{$urandom}}, 3, 3, "stall_wr");
    run_txn(1'b1, 1'b0, 32'h0000_0200, '0, 3, 3, "stall_rd");
  endtask

  task automatic test_reset_mid_burst();
    $display("txn reset_mid: read 0x300 interrupted after beat 1");
    line_read = 1'b1; line_addr = 32'h0000_0300;
    @(posedge clk); @(negedge clk);
    line_read = 1'b0;
    for (int b = 0; b < 2; b++) begin
      pmem_resp = 1'b1; pmem_rdata = mem_beat(32'h300 + 32'(8*b));
      @(posedge clk); @(negedge clk);
    end
    pmem_resp = 1'b0;
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++; $display("FAIL mid-burst pmem_read: got %b want 1", pmem_read);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_addr !== 32'h0) begin
      errors++; $display("FAIL async reset: got rd=%b wr=%b addr=%h want 0 0 0", pmem_read, pmem_write, pmem_addr);
    end
    checks++;
    if (line_rdata !== '0 || line_resp !== 1'b0) begin
      errors++; $display("FAIL async reset line: got resp=%b rdata=%h want 0 0", line_resp, line_rdata);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (line_resp !== 1'b0) begin
        errors++; $display("FAIL resp during reset: got %b want 0", line_resp);
      end
    end
    rst_n = 1'b1;
    last_rdata = '0;
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b0 || line_resp !== 1'b0) begin
      errors++; $display("FAIL after reset: got rd=%b resp=%b want 0 0", pmem_read, line_resp);
    end
    run_txn(1'b1, 1'b0, 32'h0000_0300, '0, 1, 0, "reset_retry");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      bit rd, wr;
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      // A small address pool makes reads hit previously written lines.
      run_txn(rd, wr, {24'h0, 3'($urandom), 5'($urandom)} + 32'h1000, {8{$urandom}},
              $urandom_range(0, 3), $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_both();
    test_back_to_back();
    test_stall();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
